// File: rtl/hash_table_pkg.sv
// Shared hash table types: task/result bundles, data-table word,
// command and result codes, and the init engine state encoding.
package hash_table;

  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;
  localparam int TABLE_ADDR_WIDTH = 5;
  localparam int BUCKET_WIDTH     = 5;

  typedef enum logic [1:0] {
    OP_SEARCH,
    OP_INSERT,
    OP_DELETE,
    OP_INIT
  } ht_cmd_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND,
    SEARCH_NOT_SUCCESS_NO_ENTRY,
    INSERT_SUCCESS,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL,
    DELETE_SUCCESS,
    DELETE_NOT_SUCCESS_NO_ENTRY,
    INIT_SUCCESS
  } ht_rescode_t;

  typedef struct packed {
    ht_cmd_t                cmd;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_pdata_t;

  typedef struct packed {
    ht_cmd_t                 cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    ht_rescode_t             rescode;
  } ht_result_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;

  typedef enum logic [1:0] {
    IDLE_S,
    RESET_EMPTY_PTR_STORAGE_S,
    INIT_RAMS_S,
    DO_REPORT_S
  } ht_init_state_t;

endpackage

// File: rtl/head_table_if.sv
// Head table write port: bucket address, head pointer and valid, strobe.
// The init engine drives it through the master modport.
interface head_table_if #(
  parameter int A_WIDTH = hash_table::TABLE_ADDR_WIDTH,
  parameter int B_WIDTH = hash_table::BUCKET_WIDTH
);
  logic [B_WIDTH-1:0] wr_addr;
  logic [A_WIDTH-1:0] wr_data_ptr;
  logic               wr_data_ptr_val;
  logic               wr_en;

  modport master (
    output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en
  );

  modport slave (
    input wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en
  );
endinterface

// File: rtl/ht_init_counter.sv
// Clear-sweep address counter for one table: counts 0..DEPTH-1 on writes.
// Ports: clear/stall/active in; cnt, wr_en (write this cycle), done out.
module ht_init_counter #(
  parameter int DEPTH = 16,
  parameter int W     = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear,
  input  logic         stall,
  input  logic         active,
  output logic [W-1:0] cnt,
  output logic         wr_en,
  output logic         done
);

  localparam logic [W-1:0] LAST = W'(DEPTH);

  if (DEPTH < 1 || DEPTH > (2**W) - 1) begin : g_bad_depth
    $error("ht_init_counter: DEPTH out of range for W");
  end

  assign done  = (cnt == LAST);
  assign wr_en = active && !stall && (cnt < LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wr_en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ht_table_init_ctrl.sv
// Hash table init engine: pulses empty-pointer storage reset, clears head
// and data tables, refills free pointers above RESERVED_PTRS, reports.
// Ports: task/result handshakes, data-table write port, head_table_if
// master, empty-pointer add port, wr_stall_i hold, busy_o, init_done_o.
module ht_table_init_ctrl
  import hash_table::*;
#(
  parameter int A_WIDTH       = TABLE_ADDR_WIDTH,
  parameter int DATA_DEPTH    = 2**A_WIDTH,
  parameter int HEAD_DEPTH    = 2**BUCKET_WIDTH,
  parameter int RESERVED_PTRS = 0,
  parameter bit AUTO_INIT     = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ht_pdata_t          task_i,
  input  logic               task_valid_i,
  output logic               task_ready_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output ram_data_t          wr_data_o,
  output logic               wr_en_o,
  head_table_if.master       head_table_if,
  input  logic               wr_stall_i,
  output logic               empty_ptr_storage_srst_o,
  output logic [A_WIDTH-1:0] add_empty_ptr_o,
  output logic               add_empty_ptr_en_o,
  output ht_result_t         result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               busy_o,
  output logic               init_done_o
);

  localparam int CW =
    ((A_WIDTH > BUCKET_WIDTH) ? A_WIDTH : BUCKET_WIDTH) + 1;

  if (DATA_DEPTH < 1 || DATA_DEPTH > 2**A_WIDTH) begin : g_bad_data
    $error("DATA_DEPTH out of range");
  end
  if (HEAD_DEPTH < 1 || HEAD_DEPTH > 2**BUCKET_WIDTH) begin : g_bad_head
    $error("HEAD_DEPTH out of range");
  end
  if (RESERVED_PTRS < 0 || RESERVED_PTRS >= DATA_DEPTH) begin : g_bad_res
    $error("RESERVED_PTRS must be below DATA_DEPTH");
  end

  ht_init_state_t state;
  ht_cmd_t        cmd_q;
  logic           auto_run;
  logic           done_q;

  logic          clear;
  logic          active;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] d_cnt;
  logic          h_wr;
  logic          d_wr;
  logic          h_done;
  logic          d_done;
  logic          res_ok;

  assign clear  = (state == RESET_EMPTY_PTR_STORAGE_S);
  assign active = (state == INIT_RAMS_S);

  ht_init_counter #(.DEPTH(HEAD_DEPTH), .W(CW)) u_head_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (clear),
    .stall  (wr_stall_i),
    .active (active),
    .cnt    (h_cnt),
    .wr_en  (h_wr),
    .done   (h_done)
  );

  ht_init_counter #(.DEPTH(DATA_DEPTH), .W(CW)) u_data_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (clear),
    .stall  (wr_stall_i),
    .active (active),
    .cnt    (d_cnt),
    .wr_en  (d_wr),
    .done   (d_done)
  );

  if (RESERVED_PTRS == 0) begin : g_no_res
    assign res_ok = 1'b1;
  end else begin : g_res
    assign res_ok = (d_cnt >= CW'(RESERVED_PTRS));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= AUTO_INIT ? RESET_EMPTY_PTR_STORAGE_S : IDLE_S;
      auto_run <= AUTO_INIT;
      done_q   <= 1'b0;
      cmd_q    <= OP_INIT;
    end else begin
      unique case (state)
        IDLE_S: begin
          if (task_valid_i) begin
            cmd_q    <= task_i.cmd;
            auto_run <= 1'b0;
            state    <= RESET_EMPTY_PTR_STORAGE_S;
          end
        end
        RESET_EMPTY_PTR_STORAGE_S: begin
          done_q <= 1'b0;
          state  <= INIT_RAMS_S;
        end
        INIT_RAMS_S: begin
          if (h_done && d_done) begin
            done_q   <= 1'b1;
            auto_run <= 1'b0;
            state    <= auto_run ? IDLE_S : DO_REPORT_S;
          end
        end
        DO_REPORT_S: begin
          if (result_ready_i) begin
            state <= IDLE_S;
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  assign task_ready_o = (state == IDLE_S);
  assign busy_o       = (state != IDLE_S);
  assign init_done_o  = done_q;

  // Masked by rst_i so an auto-init pulse appears only after release.
  assign empty_ptr_storage_srst_o = clear && !rst_i;

  assign wr_en_o   = d_wr;
  assign wr_addr_o = d_cnt[A_WIDTH-1:0];
  assign wr_data_o = '0;

  assign add_empty_ptr_en_o = d_wr && res_ok;
  assign add_empty_ptr_o    = d_cnt[A_WIDTH-1:0];

  assign head_table_if.wr_en           = h_wr;
  assign head_table_if.wr_addr         = h_cnt[BUCKET_WIDTH-1:0];
  assign head_table_if.wr_data_ptr     = '0;
  assign head_table_if.wr_data_ptr_val = 1'b0;

  assign result_valid_o = (state == DO_REPORT_S);
  assign result_o = '{cmd: cmd_q, bucket: '0, rescode: INIT_SUCCESS};

  logic unused_bits;
  assign unused_bits = ^{task_i.key, task_i.value,
                         h_cnt[CW-1:BUCKET_WIDTH],
                         d_cnt[CW-1:A_WIDTH]};

endmodule

// File: tb/tb_ht_table_init_ctrl.sv
// Randomized scoreboard bench for ht_table_init_ctrl (auto-init build,
// non-power-of-two data depth, reserved pointers, stalls, slow result).
module tb_ht_table_init_ctrl;
  import hash_table::*;

  localparam int AW   = TABLE_ADDR_WIDTH;
  localparam int DD   = 12;
  localparam int HD   = 32;
  localparam int RES  = 4;
  localparam int M    = (DD > HD) ? DD : HD;
  localparam int NCYC = 8192;
  localparam int INF  = 1 << 30;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_i;
  ht_pdata_t       task_i;
  logic            task_valid_i;
  logic            task_ready_o;
  logic [AW-1:0]   wr_addr_o;
  ram_data_t       wr_data_o;
  logic            wr_en_o;
  logic            wr_stall_i;
  logic            srst;
  logic [AW-1:0]   add_ptr;
  logic            add_en;
  ht_result_t      result_o;
  logic            result_valid_o;
  logic            result_ready_i;
  logic            busy_o;
  logic            init_done_o;

  head_table_if head_if();

  ht_table_init_ctrl #(
    .A_WIDTH       (AW),
    .DATA_DEPTH    (DD),
    .HEAD_DEPTH    (HD),
    .RESERVED_PTRS (RES),
    .AUTO_INIT     (1'b1)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst_i),
    .task_i                   (task_i),
    .task_valid_i             (task_valid_i),
    .task_ready_o             (task_ready_o),
    .wr_addr_o                (wr_addr_o),
    .wr_data_o                (wr_data_o),
    .wr_en_o                  (wr_en_o),
    .head_table_if            (head_if),
    .wr_stall_i               (wr_stall_i),
    .empty_ptr_storage_srst_o (srst),
    .add_empty_ptr_o          (add_ptr),
    .add_empty_ptr_en_o       (add_en),
    .result_o                 (result_o),
    .result_valid_o           (result_valid_o),
    .result_ready_i           (result_ready_i),
    .busy_o                   (busy_o),
    .init_done_o              (init_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  ev_t     dq[$];
  ev_t     hq[$];
  ev_t     aq[$];
  ht_cmd_t rq[$];
  bit      stall_pat [NCYC];
  bit      mon_en = 1'b0;

  bit exp_ready, exp_busy, exp_srst, exp_rv, exp_done, exp_take;

  int m_idle_from, m_srst_cyc, m_done_lo, m_done_hi, m_R, m_ready_block;
  bit m_pending, m_done_prev;
  int nrep = 0;

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void ev_check(string name, bit en, int addr, int which);
    ev_t e;
    bit  have;
    if (which == 0)      have = dq.size() > 0;
    else if (which == 1) have = hq.size() > 0;
    else                 have = aq.size() > 0;
    if (have) begin
      if (which == 0)      e = dq[0];
      else if (which == 1) e = hq[0];
      else                 e = aq[0];
    end
    if (en) begin
      if (!have) begin
        check({name, " unexpected"}, addr, -1);
      end else begin
        check({name, " cycle"}, cyc, e.cyc);
        check({name, " addr"}, addr, e.addr);
      end
    end else if (have && e.cyc <= cyc) begin
      check({name, " missing"}, -1, e.addr);
    end
    if (have && (en || e.cyc <= cyc)) begin
      if (which == 0)      void'(dq.pop_front());
      else if (which == 1) void'(hq.pop_front());
      else                 void'(aq.pop_front());
    end
  endfunction

  function automatic bit done_at(int c);
    if (c >= m_done_hi) return 1'b1;
    if (c >= m_done_lo) return 1'b0;
    return m_done_prev;
  endfunction

  function automatic void reset_model();
    dq.delete();
    hq.delete();
    aq.delete();
    rq.delete();
    m_idle_from   = INF;
    m_srst_cyc    = -1;
    m_done_lo     = INF;
    m_done_hi     = INF;
    m_done_prev   = 1'b0;
    m_R           = INF;
    m_pending     = 1'b0;
    m_ready_block = 0;
  endfunction

  // Accepted at cycle t: srst at t+1, then one write slot per unstalled
  // cycle from t+2 until every entry of both tables has been cleared.
  function automatic void plan(int t, bit report, ht_cmd_t cmd);
    int c, d, h, mode;
    mode = $urandom_range(0, 2);
    for (int i = t + 1; i < t + 1 + 4 * M && i < NCYC; i++) begin
      if (mode == 1)      stall_pat[i] = ($urandom_range(0, 4) == 0);
      else if (mode == 2) stall_pat[i] = (i >= t + 6 && i < t + 11);
      else                stall_pat[i] = 1'b0;
    end
    c = t + 2;
    d = 0;
    h = 0;
    while ((d < DD || h < HD) && c < NCYC) begin
      if (!stall_pat[c]) begin
        if (d < DD) begin
          dq.push_back('{c, d});
          if (d >= RES) aq.push_back('{c, d});
          d++;
        end
        if (h < HD) begin
          hq.push_back('{c, h});
          h++;
        end
      end
      c++;
    end
    m_done_prev = done_at(t + 1);
    m_srst_cyc  = t + 1;
    m_done_lo   = t + 2;
    m_done_hi   = c + 1;
    if (report) begin
      m_pending   = 1'b1;
      m_R         = c + 1;
      m_idle_from = INF;
      rq.push_back(cmd);
      m_ready_block = (nrep == 0 || $urandom_range(0, 2) == 0) ? c + 8 : 0;
      nrep++;
    end else begin
      m_idle_from = c + 1;
    end
  endfunction

  task automatic cycle_step(bit allow, bit rel);
    int c;
    bit v;
    @(posedge clk);
    #1;
    c = cyc;
    if (rel) begin
      rst_i = 1'b0;
      reset_model();
      plan(c - 1, 1'b0, OP_INIT);
      mon_en = 1'b1;
    end
    wr_stall_i     = (c < NCYC) ? stall_pat[c] : 1'b0;
    result_ready_i = (c >= m_ready_block) && ($urandom_range(0, 3) != 0);
    v              = allow && ($urandom_range(0, 2) == 0);
    task_valid_i   = v;
    task_i = '{cmd: ht_cmd_t'($urandom_range(0, 3)),
               key: 16'($urandom), value: 16'($urandom)};
    exp_rv    = m_pending && c >= m_R;
    exp_take  = exp_rv && result_ready_i;
    exp_ready = (c >= m_idle_from);
    exp_busy  = !exp_ready;
    exp_srst  = (c == m_srst_cyc);
    exp_done  = done_at(c);
    if (exp_take) begin
      m_pending   = 1'b0;
      m_idle_from = c + 1;
    end
    if (exp_ready && v) plan(c, 1'b1, task_i.cmd);
  endtask

  task automatic check_reset();
    check("rst task_ready", int'(task_ready_o), 0);
    check("rst busy", int'(busy_o), 1);
    check("rst srst", int'(srst), 0);
    check("rst wr_en", int'(wr_en_o), 0);
    check("rst head wr_en", int'(head_if.wr_en), 0);
    check("rst add_en", int'(add_en), 0);
    check("rst result_valid", int'(result_valid_o), 0);
    check("rst init_done", int'(init_done_o), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("task_ready", int'(task_ready_o), int'(exp_ready));
      check("busy", int'(busy_o), int'(exp_busy));
      check("srst", int'(srst), int'(exp_srst));
      check("result_valid", int'(result_valid_o), int'(exp_rv));
      check("init_done", int'(init_done_o), int'(exp_done));
      ev_check("data_wr", wr_en_o, int'(wr_addr_o), 0);
      ev_check("head_wr", head_if.wr_en, int'(head_if.wr_addr), 1);
      ev_check("add_ptr", add_en, int'(add_ptr), 2);
      if (wr_en_o)
        check("wr_data nonzero", int'(wr_data_o != '0), 0);
      if (head_if.wr_en)
        check("head data nonzero",
              int'({head_if.wr_data_ptr_val, head_if.wr_data_ptr} != '0), 0);
      if (result_valid_o) begin
        if (rq.size() == 0) begin
          check("result unexpected", 1, 0);
        end else begin
          check("result cmd", int'(result_o.cmd), int'(rq[0]));
          check("result rescode", int'(result_o.rescode), int'(INIT_SUCCESS));
          check("result bucket", int'(result_o.bucket), 0);
        end
      end
      if (exp_take && rq.size() > 0) void'(rq.pop_front());
    end
  end

  initial begin
    bit drained;
    rst_i          = 1'b1;
    task_valid_i   = 1'b0;
    task_i         = '0;
    wr_stall_i     = 1'b0;
    result_ready_i = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset();

    cycle_step(1'b0, 1'b1);
    repeat (12) cycle_step(1'b0, 1'b0);

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check_reset();
    reset_model();
    repeat (2) @(posedge clk);

    cycle_step(1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) cycle_step(1'b1, 1'b0);

    drained = 1'b0;
    for (int i = 0; i < 600 && !drained; i++) begin
      cycle_step(1'b0, 1'b0);
      drained = (cyc >= m_idle_from) && dq.size() == 0 &&
                hq.size() == 0 && aq.size() == 0 && rq.size() == 0;
    end
    check("drain finished", int'(drained), 1);
    repeat (3) cycle_step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("leftover events",
          dq.size() + hq.size() + aq.size() + rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
